mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between the instruction-fetch path and the load/store path.
- Arbitrates between the two requesters and sequences each access through a fixed-latency memory.
- Applies byte/half/word lane steering: store byte enables and data replication, load extraction with sign or zero extension.
- Flags misaligned data accesses. Sits between the fetch stage, the LSU (driven by the decoder's size/unsigned/write controls) and the memory macro.

Parameters:
- MEM_LATENCY, 1: cycles from the mem_en cycle to the cycle mem_rdata is valid; legal values ≥1.
- MAX_DATA_STREAK, 4: maximum consecutive data grants while a fetch request is waiting; legal values ≥1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  32  fetch byte address
- if_resp_valid  out  1  fetch data valid (1-cycle pulse)
- if_rdata  out  32  fetched word
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle
- d_addr  in  32  data byte address
- d_we  in  1  1=store, 0=load
- d_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- d_unsigned  in  1  zero-extend load (LBU/LHU)
- d_wdata  in  32  store data in low bits
- d_resp_valid  out  1  data response (1-cycle pulse; load data or store ack)
- d_rdata  out  32  extended load data; 0 for stores and errors
- d_misaligned  out  1  qualifies d_resp_valid: access rejected
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_be  out  4  byte enables
- mem_addr  out  32  word-aligned address, bits[1:0]=0
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  memory read data

Behaviour:
- Reset: async on rst_n low. Every output goes to 0, state goes to IDLE, streak counter goes to 0. Any in-flight access is abandoned and its response is never delivered; mem_en drops immediately.
- FSM states: IDLE, ISSUE, WAIT, RESP. One access is outstanding at a time.
- Readies are combinational and asserted only in IDLE, for the arbitration winner only. Requesters hold valid and payload stable until ready; the payload is latched on acceptance.
- Arbitration: data wins over fetch. Exception: fetch wins if streak==MAX_DATA_STREAK and if_req_valid is high.
  - Streak increments on a data grant while if_req_valid is high.
  - Streak clears on any fetch grant, or on a data grant while fetch is idle.
- Timing for an access accepted in cycle T:
  - T+1 (ISSUE): mem_en=1 for exactly one cycle with the latched we/be/addr/wdata.
  - Stores: RESP at T+2 with d_resp_valid=1, then IDLE.
  - Loads/fetches: WAIT counts MEM_LATENCY−1 extra cycles. mem_rdata is sampled at T+1+MEM_LATENCY. RESP at T+2+MEM_LATENCY pulses the matching resp_valid with registered data, then IDLE.
- Fetch: if_addr[1:0] are ignored; mem_be=1111, mem_we=0.
- Byte enables:
  - byte: 0001<<addr[1:0]
  - half: 0011<<{addr[1],1'b0}
  - word: 1111
- mem_wdata replication: byte data replicated ×4; half data replicated ×2.
- Loads: select the lane by offset, then sign-extend (d_unsigned=0) or zero-extend.
- Misaligned data access (any one of these):
  - half with addr[0]=1
  - word with addr[1:0]≠00
  - d_size=11

  It is accepted normally but mem_en is never asserted. State goes IDLE→RESP. d_resp_valid=1 and d_misaligned=1 at T+1, d_rdata=0.
- Simultaneous valids in IDLE: exactly one ready is high. The loser's valid stays pending and the loser is not accepted.
- Responses are not back-pressured; requesters must accept them.

Decomposition:
- Package mem_pkg holds:
  - size constants SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10
  - FSM state enum
  - requester-id enum (REQ_IF, REQ_D)
- One combinational sub-module, mem_lane_align, contains all lane logic: byte-enable generation, store replication, load extract/extend, misalignment check. It is reused by the future cache.

Test Plan:
- MEM_LATENCY=1. Fetch at 0x100, mem_rdata=0xDEADBEEF → if_req_ready at T; mem_en at T+1 with mem_addr=0x100, be=1111; if_resp_valid with 0xDEADBEEF at T+3.
- LB from 0x203, memory word 0x80112233 → mem_be=1000; d_rdata=0xFFFFFF80. LBU at the same address → d_rdata=0x00000080.
- SH with d_wdata=0x0000ABCD to 0x302 → mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1; d_resp_valid at T+2.
- LW from 0x401 → d_resp_valid and d_misaligned at T+1, d_rdata=0, mem_en never high. Repeat with d_size=11 → same result.
- Both valid continuously, MAX_DATA_STREAK=4 → grant order D,D,D,D,IF,D,D,D,D,IF.
- rst_n low during WAIT of a load → mem_en and all resp_valid outputs 0 immediately. After release the FSM is in IDLE, accepts a new fetch normally, and no stale response appears.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the unified-memory port: access sizes, arbiter FSM states, requester ids.
// Combinational definitions only; no latency or backpressure of its own.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables and replication, load extract/extend, misalignment check.
// Purely combinational (0 cycles); no backpressure.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        case (off_i)
            2'd0:    rbyte = rdata_i[7:0];
            2'd1:    rbyte = rdata_i[15:8];
            2'd2:    rbyte = rdata_i[23:16];
            default: rbyte = rdata_i[31:24];
        endcase
        rhalf = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        be_o         = 4'b0000;
        wdata_o      = wdata_i;
        rdata_o      = 32'h0;
        misaligned_o = 1'b0;
        case (size_i)
            SIZE_BYTE: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{~unsigned_i & rbyte[7]}}, rbyte};
            end
            SIZE_HALF: begin
                be_o         = 4'b0011 << {off_i[1], 1'b0};
                wdata_o      = {2{wdata_i[15:0]}};
                rdata_o      = {{16{~unsigned_i & rhalf[15]}}, rhalf};
                misaligned_o = off_i[0];
            end
            SIZE_WORD: begin
                be_o         = 4'b1111;
                rdata_o      = rdata_i;
                misaligned_o = |off_i;
            end
            default: misaligned_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch vs load/store onto one fixed-latency memory, one access outstanding at a time.
// Latency: store 2, load/fetch 2+MEM_LATENCY, misaligned 1 cycle; readies only in IDLE, responses not back-pressured.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned MEM_LATENCY     = 1,
    parameter int unsigned MAX_DATA_STREAK = 4
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_resp_valid,
    output logic [31:0] if_rdata,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_wdata,
    output logic        d_resp_valid,
    output logic [31:0] d_rdata,
    output logic        d_misaligned,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int unsigned STK_W = $clog2(MAX_DATA_STREAK + 1);

    state_t             state_q, state_d;
    req_id_t            id_q, id_d;
    logic               we_q, we_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [1:0]         off_q, off_d;
    logic               misal_q, misal_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [CNT_W-1:0]   lat_q, lat_d;
    logic [STK_W-1:0]   streak_q, streak_d;

    logic        idle, fetch_first, grant_d, grant_if;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_rdata;
    logic        al_misal;
    logic        unused_if_off;

    assign unused_if_off = ^if_addr[1:0];

    assign idle        = (state_q == ST_IDLE);
    assign fetch_first = if_req_valid && (streak_q == STK_W'(MAX_DATA_STREAK));
    assign grant_d     = idle && d_req_valid && !fetch_first;
    assign grant_if    = idle && if_req_valid && !grant_d;
    assign d_req_ready  = grant_d;
    assign if_req_ready = grant_if;

    // Live request drives the lanes while idle; the latched access drives them during the read.
    mem_lane_align u_align (
        .off_i        (idle ? d_addr[1:0] : off_q),
        .size_i       (idle ? d_size : size_q),
        .unsigned_i   (idle ? d_unsigned : uns_q),
        .wdata_i      (d_wdata),
        .rdata_i      (mem_rdata),
        .be_o         (al_be),
        .wdata_o      (al_wdata),
        .rdata_o      (al_rdata),
        .misaligned_o (al_misal)
    );

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        we_d     = we_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        size_d   = size_q;
        uns_d    = uns_q;
        off_d    = off_q;
        misal_d  = misal_q;
        rdata_d  = rdata_q;
        lat_d    = lat_q;
        streak_d = streak_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_d) begin
                    id_d     = REQ_D;
                    we_d     = d_we & ~al_misal;
                    be_d     = al_misal ? 4'b0000 : al_be;
                    addr_d   = {d_addr[31:2], 2'b00};
                    wdata_d  = al_wdata;
                    size_d   = d_size;
                    uns_d    = d_unsigned;
                    off_d    = d_addr[1:0];
                    misal_d  = al_misal;
                    rdata_d  = 32'h0;
                    state_d  = al_misal ? ST_RESP : ST_ISSUE;
                    streak_d = if_req_valid ? streak_q + STK_W'(1) : '0;
                end else if (grant_if) begin
                    id_d     = REQ_IF;
                    we_d     = 1'b0;
                    be_d     = 4'b1111;
                    addr_d   = {if_addr[31:2], 2'b00};
                    wdata_d  = 32'h0;
                    misal_d  = 1'b0;
                    rdata_d  = 32'h0;
                    state_d  = ST_ISSUE;
                    streak_d = '0;
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                    lat_d   = CNT_W'(MEM_LATENCY - 1);
                end
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    rdata_d = (id_q == REQ_IF) ? mem_rdata : al_rdata;
                    state_d = ST_RESP;
                end else begin
                    lat_d = lat_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            id_q     <= REQ_IF;
            we_q     <= 1'b0;
            be_q     <= 4'b0000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            off_q    <= 2'b00;
            misal_q  <= 1'b0;
            rdata_q  <= 32'h0;
            lat_q    <= '0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            we_q     <= we_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            off_q    <= off_d;
            misal_q  <= misal_d;
            rdata_q  <= rdata_d;
            lat_q    <= lat_d;
            streak_q <= streak_d;
        end
    end

    assign mem_en    = (state_q == ST_ISSUE);
    assign mem_we    = mem_en & we_q;
    assign mem_be    = mem_en ? be_q : 4'b0000;
    assign mem_addr  = mem_en ? addr_q : 32'h0;
    assign mem_wdata = mem_en ? wdata_q : 32'h0;

    assign if_resp_valid = (state_q == ST_RESP) && (id_q == REQ_IF);
    assign d_resp_valid  = (state_q == ST_RESP) && (id_q == REQ_D);
    assign if_rdata      = if_resp_valid ? rdata_q : 32'h0;
    assign d_rdata       = d_resp_valid ? rdata_q : 32'h0;
    assign d_misaligned  = d_resp_valid & misal_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases, fetch/data arbitration, reset abort and random traffic
// checked against a byte-addressed reference memory.
module tb_mem_port_arbiter;

    localparam int LAT  = 1;
    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, if_req_ready, if_resp_valid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req_valid, d_req_ready, d_we, d_unsigned, d_resp_valid, d_misaligned;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.MEM_LATENCY(LAT), .MAX_DATA_STREAK(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned), .d_wdata(d_wdata),
        .d_resp_valid(d_resp_valid), .d_rdata(d_rdata), .d_misaligned(d_misaligned),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] macro_mem [0:1023];
    logic [7:0]  ref_mem   [0:4095];
    logic [31:0] mword;
    int n_chk = 0;
    int n_err = 0;

    // Memory macro: one-cycle read latency, byte-enabled writes.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mword = macro_mem[mem_addr[11:2]];
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mword[8*b +: 8] = mem_wdata[8*b +: 8];
                macro_mem[mem_addr[11:2]] = mword;
            end else begin
                mem_rdata <= macro_mem[mem_addr[11:2]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        macro_mem[a[11:2]] = w;
        for (int i = 0; i < 4; i++) ref_mem[{a[11:2], 2'b00} + 12'(i)] = w[8*i +: 8];
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int nb, input bit uns);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[12'(a + 32'(i))]) << (8 * i));
        if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        return v;
    endfunction

    // One isolated request, starting just after a falling edge; ends on a falling edge with the DUT idle.
    task automatic txn(input bit is_f, input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd);
        bit          mis;
        int          nb, off, rc;
        logic [3:0]  ebe;
        logic [31:0] ewd, erd;
        off = int'(a[1:0]);
        nb  = 1 << sz;
        mis = !is_f && (sz == 2'b11 || (off % nb) != 0);
        if (is_f) begin
            we  = 1'b0;
            ebe = 4'hF;
            ewd = 32'h0;
            erd = ref_load(a & ~32'h3, 4, 1'b1);
        end else begin
            ebe = 4'(((1 << nb) - 1) << off);
            for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % nb) +: 8];
            erd = (we || mis) ? 32'h0 : ref_load(a, nb, uns);
        end
        rc = mis ? 1 : (we ? 2 : 2 + LAT);
        if (is_f) begin
            if_req_valid = 1'b1; if_addr = a;
        end else begin
            d_req_valid = 1'b1; d_addr = a; d_we = we; d_size = sz; d_unsigned = uns; d_wdata = wd;
        end
        #1;
        chk("ready", 32'(is_f ? if_req_ready : d_req_ready), 32'd1);
        chk("other_ready", 32'(is_f ? d_req_ready : if_req_ready), 32'd0);
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        if (!is_f && we && !mis)
            for (int i = 0; i < nb; i++) ref_mem[12'(a + 32'(i))] = wd[8*i +: 8];
        for (int k = 1; k <= 3 + LAT; k++) begin
            @(negedge clk);
            chk("mem_en", 32'(mem_en), 32'(k == 1 && !mis));
            if (k == 1 && !mis) begin
                chk("mem_addr", mem_addr, a & ~32'h3);
                chk("mem_be", 32'(mem_be), 32'(ebe));
                chk("mem_we", 32'(mem_we), 32'(we));
                if (we) chk("mem_wdata", mem_wdata, ewd);
            end
            chk("if_resp_valid", 32'(if_resp_valid), 32'(is_f && k == rc));
            chk("d_resp_valid", 32'(d_resp_valid), 32'(!is_f && k == rc));
            if (k == rc) begin
                if (is_f) chk("if_rdata", if_rdata, erd);
                else begin
                    chk("d_rdata", d_rdata, erd);
                    chk("d_misaligned", 32'(d_misaligned), 32'(mis));
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ng, cyc, exp_d;
        bit f, w, u;
        logic [1:0]  sz;
        logic [31:0] a;

        rst_n = 1'b0;
        if_req_valid = 1'b0; if_addr = 32'h0;
        d_req_valid = 1'b0; d_addr = 32'h0; d_we = 1'b0; d_size = 2'b00;
        d_unsigned = 1'b0; d_wdata = 32'h0; mem_rdata = 32'h0;
        for (int i = 0; i < 1024; i++) preload(32'(i * 4), $urandom);
        #12;
        chk("rst_if_ready", 32'(if_req_ready), 32'd0);
        chk("rst_d_ready", 32'(d_req_ready), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_if_resp", 32'(if_resp_valid), 32'd0);
        chk("rst_d_resp", 32'(d_resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        preload(32'h100, 32'hDEAD_BEEF);
        txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        preload(32'h200, 32'h8011_2233);
        txn(1'b0, 1'b0, 2'b00, 1'b0, 32'h203, 32'h0);
        txn(1'b0, 1'b0, 2'b00, 1'b1, 32'h203, 32'h0);
        txn(1'b0, 1'b1, 2'b01, 1'b0, 32'h302, 32'h0000_ABCD);
        txn(1'b0, 1'b0, 2'b01, 1'b0, 32'h302, 32'h0);
        txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h401, 32'h0);
        txn(1'b0, 1'b0, 2'b11, 1'b0, 32'h400, 32'h0);

        // Both requesters hold valid: data gets MAXS grants, then fetch gets one
        if_addr = 32'h100; d_addr = 32'h200; d_we = 1'b0; d_size = 2'b10; d_unsigned = 1'b0;
        if_req_valid = 1'b1; d_req_valid = 1'b1;
        ng = 0; cyc = 0;
        while (ng < 10 && cyc < 300) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            #1;
            chk("one_ready", 32'(if_req_ready & d_req_ready), 32'd0);
            if (if_req_ready || d_req_ready) begin
                exp_d = ((ng % (MAXS + 1)) == MAXS) ? 0 : 1;
                chk($sformatf("grant%0d", ng), 32'(d_req_ready), 32'(exp_d));
                ng++;
            end
        end
        if (ng < 10) chk("arb_timeout", 32'(ng), 32'd10);
        @(posedge clk);
        #1;
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (6) @(negedge clk);

        // Reset while a load sits in WAIT
        d_addr = 32'h200; d_size = 2'b10; d_we = 1'b0; d_req_valid = 1'b1;
        @(posedge clk); #1; d_req_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rstw_mem_en", 32'(mem_en), 32'd0);
        chk("rstw_d_resp", 32'(d_resp_valid), 32'd0);
        chk("rstw_if_resp", 32'(if_resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stale_d_resp", 32'(d_resp_valid), 32'd0);
            chk("stale_mem_en", 32'(mem_en), 32'd0);
        end
        txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0);

        // Reset while the access is being issued: strobe must drop at once
        if_addr = 32'h108; if_req_valid = 1'b1;
        @(posedge clk); #1; if_req_valid = 1'b0;
        @(negedge clk);
        chk("issue_mem_en", 32'(mem_en), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rsti_mem_en", 32'(mem_en), 32'd0);
        chk("rsti_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stale_if_resp", 32'(if_resp_valid), 32'd0);
        end

        // Random single-requester traffic
        for (int t = 0; t < 80; t++) begin
            f  = ($urandom_range(0, 3) == 0);
            w  = $urandom_range(0, 1) == 1;
            u  = $urandom_range(0, 1) == 1;
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 1023) * 4);
            if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(0, 3));
            else if (sz == 2'b00) a = a + 32'($urandom_range(0, 3));
            else if (sz == 2'b01) a = a + 32'(2 * $urandom_range(0, 1));
            txn(f, w, sz, u, a, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
